expr_stream_arbiter: RTL and testbench
======================================

Name: expr_stream_arbiter

Overview:
Shares one expression-recognizer datapath (8-bit char in, 1-bit match out, async clear) between two character-stream requesters. Arbitration is round-robin, one whole space-terminated expression per grant. The granted expression is buffered in a local line buffer, then burst contiguously into the recognizer so it never sees bubbles. The match verdict is returned tagged with the requester id. Sits between the input front-ends and the recognizer instance.

Parameters:
DEPTH, 16, max non-terminator chars per expression held in the line buffer
TERM, 8'h20, terminator character (space); never forwarded to the recognizer
CNT_W, $clog2(DEPTH+1), derived count width; not overridden

Ports:
clk  in  1  system clock, all state on posedge
clr  in  1  reset, asynchronous, active-high
req_valid  in  2  per-requester char valid
req_char  in  16  packed chars; requester i on [8i+7:8i]
req_ready  out  2  per-requester ready; char transfers on valid&&ready
rec_clr  out  1  clear to recognizer, active-high
rec_in  out  8  char to recognizer, consumed each posedge while rec_clr low
rec_out  in  1  recognizer verdict for chars consumed so far; valid after the consuming edge
res_valid  out  1  one-cycle result strobe
res_id  out  1  requester the result belongs to
res_match  out  1  recognizer verdict; 0 on empty or overflow
res_ovf  out  1  expression exceeded DEPTH
busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: req_ready=0, rec_clr=1, rec_in=0, res_valid=0, res_id=0, res_match=0, res_ovf=0, busy=0, state=IDLE, last_grant=1 (requester 0 wins first), count=0.
- rec_clr = clr OR (state not in {FEED, WAIT}); asserts combinationally on clr.
- States: IDLE -> LOAD -> FEED -> WAIT -> DONE -> IDLE.
- IDLE: if any req_valid, latch grant. Single requester: that one. Both: the one != last_grant. Set last_grant=grant. No char accepted in IDLE.
- LOAD: req_ready[grant]=1, other=0. Each transfer:
  - char==TERM with count==0: go to DONE, match=0, ovf=0 (empty).
  - char==TERM with count>0: go to FEED.
  - otherwise, if count<DEPTH: write buf[count], count++.
  - otherwise: set ovf, discard char.
  - TERM while ovf set: go to DONE, match=0, ovf=1; the recognizer is never cleared low.
  - Requester stalls in LOAD only lengthen LOAD.
- FEED: rec_in=buf[rd], rd runs 0..count-1, exactly count consecutive cycles, no gaps. req_ready=0.
- WAIT: one cycle, rec_in=0. On its closing posedge, capture rec_out into res_match.
- DONE: res_valid=1 for one cycle with res_id=grant and res_ovf. Clear count, rd and ovf. Return to IDLE.
- res_match, res_id and res_ovf hold until the next DONE.
- Latency, N chars with no stalls: IDLE 1 + LOAD N+1 + FEED N + WAIT 1, then res_valid high in the next cycle. rec_clr is low for exactly N+1 cycles.
- clr mid-operation: everything returns to reset values immediately; the buffered expression is lost with no result; a requester mid-stream must resend.
- At most one expression in flight; the losing requester waits with req_ready=0.

Decomposition:
- Package expr_pkg: state enum {IDLE, LOAD, FEED, WAIT, DONE}, CHAR_W=8, TERM default, requester count 2.
- Sub-module expr_line_buf: DEPTH x 8 storage plus write/read pointers and count.
  - Write port: we, wdata.
  - Read port: rd_en, rdata (combinational from rd pointer).
  - Pointer clear input.
  - Async clr.

Test Plan:
- Req0 sends "1+(1+2)*(1*3) " one char per cycle -> 13 FEED cycles with rec_in matching the chars in order; rec_clr low 14 cycles; res_valid, res_id=0, res_match=1, res_ovf=0.
- Req1 sends "1+*2 " -> 4 FEED cycles; res_id=1, res_match=0.
- Req0 and req1 assert together right after reset -> req0 served first, then req1. A second simultaneous pair is served 0 then 1 again (alternation from last_grant=1). Three back-to-back req1-only expressions are all served.
- Req0 sends " " -> res_valid, res_match=0, res_ovf=0; rec_clr never drops.
- DEPTH=4, req0 sends "1+2+3 " -> 6 transfers accepted; rec_clr stays high; res_ovf=1, res_match=0.
- clr pulse mid-FEED -> same cycle rec_clr=1, req_ready=0, busy=0, no res_valid. A following "1 " yields res_match=1. Random req_valid gaps in LOAD never produce gaps in FEED.

Source files
------------

// File: rtl/expr_pkg.sv
// Shared types and constants for the two-requester expression stream arbiter.
package expr_pkg;

  localparam int CHAR_W  = 8;
  localparam int NUM_REQ = 2;
  localparam logic [CHAR_W-1:0] TERM_DEF = 8'h20;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    FEED = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/expr_line_buf.sv
// Line buffer holding one expression: write pointer doubles as the character count,
// read pointer walks the stored characters during the burst into the recognizer.
module expr_line_buf
  import expr_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ptr_clr,
  input  logic              we,
  input  logic [CHAR_W-1:0] wdata,
  input  logic              rd_en,
  output logic [CHAR_W-1:0] rdata,
  output logic [CNT_W-1:0]  count,
  output logic              rd_last
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CHAR_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  rd_ptr;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count  <= '0;
      rd_ptr <= '0;
    end else if (ptr_clr) begin
      count  <= '0;
      rd_ptr <= '0;
    end else begin
      if (we)    count  <= count + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[count[AW-1:0]] <= wdata;
  end

  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign rd_last = (rd_ptr + 1'b1) == count;

endmodule

// File: rtl/expr_stream_arbiter.sv
// Round-robin arbiter sharing one expression recognizer between two character streams;
// each grant buffers a whole space-terminated expression and bursts it without bubbles.
module expr_stream_arbiter
  import expr_pkg::*;
#(
  parameter int                DEPTH = 16,
  parameter logic [CHAR_W-1:0] TERM  = TERM_DEF
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*CHAR_W-1:0] req_char,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rec_clr,
  output logic [CHAR_W-1:0]         rec_in,
  input  logic                      rec_out,
  output logic                      res_valid,
  output logic                      res_id,
  output logic                      res_match,
  output logic                      res_ovf,
  output logic                      busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  state_t            state, state_nxt;
  logic              grant, grant_nxt, last_grant;
  logic              ovf, set_ovf;
  logic              we, rd_en, ptr_clr, rd_last;
  logic              res_load, res_match_d, res_ovf_d;
  logic [CHAR_W-1:0] cur_char, rdata;
  logic [CNT_W-1:0]  count;

  expr_line_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_buf (
    .clk     (clk),
    .clr     (clr),
    .ptr_clr (ptr_clr),
    .we      (we),
    .wdata   (cur_char),
    .rd_en   (rd_en),
    .rdata   (rdata),
    .count   (count),
    .rd_last (rd_last)
  );

  assign cur_char = req_char[int'(grant)*CHAR_W +: CHAR_W];

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    req_ready   = '0;
    rec_in      = '0;
    we          = 1'b0;
    rd_en       = 1'b0;
    ptr_clr     = 1'b0;
    set_ovf     = 1'b0;
    res_load    = 1'b0;
    res_match_d = 1'b0;
    res_ovf_d   = 1'b0;
    unique case (state)
      IDLE: if (|req_valid) begin
        grant_nxt = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        state_nxt = LOAD;
      end
      LOAD: begin
        req_ready[grant] = 1'b1;
        if (req_valid[grant]) begin
          if (cur_char == TERM) begin
            // Empty or overflowed expressions never reach the recognizer.
            if (ovf || count == '0) begin
              state_nxt = DONE;
              res_load  = 1'b1;
              res_ovf_d = ovf;
            end else begin
              state_nxt = FEED;
            end
          end else if (count < FULL) begin
            we = 1'b1;
          end else begin
            set_ovf = 1'b1;
          end
        end
      end
      FEED: begin
        rd_en  = 1'b1;
        rec_in = rdata;
        if (rd_last) state_nxt = WAIT;
      end
      WAIT: begin
        state_nxt   = DONE;
        res_load    = 1'b1;
        res_match_d = rec_out;
      end
      DONE: begin
        ptr_clr   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      ovf        <= 1'b0;
      res_id     <= 1'b0;
      res_match  <= 1'b0;
      res_ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (state == IDLE && state_nxt == LOAD) last_grant <= grant_nxt;
      if (set_ovf)            ovf <= 1'b1;
      else if (state == DONE) ovf <= 1'b0;
      if (res_load) begin
        res_id    <= grant;
        res_match <= res_match_d;
        res_ovf   <= res_ovf_d;
      end
    end
  end

  assign rec_clr   = clr || !(state == FEED || state == WAIT);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_expr_stream_arbiter.sv
// Directed bench for expr_stream_arbiter: two instances (DEPTH 16 and 4) each driving a
// small behavioural expression recognizer; expected verdicts are hand-computed per vector.
module tb_expr_stream_arbiter;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [1:0]  rv        [2];
  logic [15:0] rc        [2];
  logic [1:0]  rr        [2];
  logic        rec_clr   [2];
  logic [7:0]  rec_in    [2];
  logic        rec_out   [2];
  logic        res_valid [2];
  logic        res_id    [2];
  logic        res_match [2];
  logic        res_ovf   [2];
  logic        busy      [2];

  int n_checks = 0;
  int n_err    = 0;
  int act      = 0;
  int cyc      = 0;
  int xfer_cnt = 0;
  int res_cyc  = 0;
  int start_cyc = 0;
  int both_rdy = 0;
  logic [7:0] feed_q [$];
  logic [2:0] res_q  [$];

  // Recognizer model state: error seen, operand expected next, open parentheses.
  logic m_err [2];
  logic m_need [2];
  int   m_depth [2];

  always #5 clk = ~clk;

  expr_stream_arbiter #(.DEPTH(16)) u_dut0 (
    .clk(clk), .clr(clr), .req_valid(rv[0]), .req_char(rc[0]), .req_ready(rr[0]),
    .rec_clr(rec_clr[0]), .rec_in(rec_in[0]), .rec_out(rec_out[0]),
    .res_valid(res_valid[0]), .res_id(res_id[0]), .res_match(res_match[0]),
    .res_ovf(res_ovf[0]), .busy(busy[0])
  );

  expr_stream_arbiter #(.DEPTH(4)) u_dut4 (
    .clk(clk), .clr(clr), .req_valid(rv[1]), .req_char(rc[1]), .req_ready(rr[1]),
    .rec_clr(rec_clr[1]), .rec_in(rec_in[1]), .rec_out(rec_out[1]),
    .res_valid(res_valid[1]), .res_id(res_id[1]), .res_match(res_match[1]),
    .res_ovf(res_ovf[1]), .busy(busy[1])
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      logic [7:0] c;
      c = rec_in[i];
      if (rec_clr[i]) begin
        m_err[i]   <= 1'b0;
        m_need[i]  <= 1'b1;
        m_depth[i] <= 0;
      end else if (c != 8'h00) begin
        if (c >= "0" && c <= "9") begin
          if (!m_need[i]) m_err[i] <= 1'b1;
          m_need[i] <= 1'b0;
        end else if (c == "(") begin
          if (!m_need[i]) m_err[i] <= 1'b1;
          m_depth[i] <= m_depth[i] + 1;
        end else if (c == ")") begin
          if (m_need[i] || m_depth[i] == 0) m_err[i] <= 1'b1;
          else m_depth[i] <= m_depth[i] - 1;
        end else if (c == "+" || c == "*") begin
          if (m_need[i]) m_err[i] <= 1'b1;
          m_need[i] <= 1'b1;
        end else begin
          m_err[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) rec_out[i] = !m_err[i] && !m_need[i] && (m_depth[i] == 0);
  end

  always @(negedge clk) begin
    if (!rec_clr[act]) feed_q.push_back(rec_in[act]);
    if (res_valid[act]) begin
      res_q.push_back({res_id[act], res_match[act], res_ovf[act]});
      res_cyc = cyc;
    end
    if (rr[act] == 2'b11) both_rdy++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int id, input string s, input bit gaps);
    int t;
    for (int i = 0; i < s.len(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      rv[act][id] = 1'b1;
      rc[act][id*8 +: 8] = s[i];
      t = 0;
      while (!rr[act][id] && t <= 300) begin
        @(negedge clk);
        t++;
      end
      if (t > 300) begin
        check("ready_wait", t, 0);
        rv[act][id] = 1'b0;
        return;
      end
      @(posedge clk);
      xfer_cnt++;
      @(negedge clk);
      rv[act][id] = 1'b0;
    end
  endtask

  task automatic wait_result(input int n);
    int t = 0;
    while (res_q.size() < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("res_count", res_q.size(), n);
  endtask

  task automatic clear_obs();
    feed_q.delete();
    res_q.delete();
    xfer_cnt = 0;
  endtask

  task automatic run_one(input int id, input string s, input bit gaps, input bit exp_m,
                         input bit exp_o, input int exp_low, input bit chk_lat);
    int n = s.len() - 1;
    clear_obs();
    start_cyc = cyc;
    drive(id, s, gaps);
    wait_result(1);
    if (res_q.size() > 0) begin
      check({s, ":res_id"},    res_q[0][2], id);
      check({s, ":res_match"}, res_q[0][1], exp_m);
      check({s, ":res_ovf"},   res_q[0][0], exp_o);
    end
    check({s, ":rec_clr_low"}, feed_q.size(), exp_low);
    check({s, ":xfers"}, xfer_cnt, s.len());
    if (exp_low > 0 && feed_q.size() == exp_low) begin
      for (int k = 0; k < n; k++) check($sformatf("%s:feed%0d", s, k), feed_q[k], s[k]);
      check({s, ":wait_in"}, feed_q[n], 0);
    end
    if (chk_lat) check({s, ":latency"}, res_cyc - start_cyc, 2 * n + 3);
    @(negedge clk);
  endtask

  task automatic run_pair(input string s0, input string s1, input bit m0, input bit m1);
    clear_obs();
    fork
      drive(0, s0, 1'b0);
      drive(1, s1, 1'b0);
    join
    wait_result(2);
    if (res_q.size() == 2) begin
      check("pair_first_id",     res_q[0][2], 0);
      check("pair_first_match",  res_q[0][1], m0);
      check("pair_second_id",    res_q[1][2], 1);
      check("pair_second_match", res_q[1][1], m1);
    end
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    for (int i = 0; i < 2; i++) begin
      rv[i] = '0;
      rc[i] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_req_ready", rr[0], 0);
    check("rst_rec_clr",   rec_clr[0], 1);
    check("rst_rec_in",    rec_in[0], 0);
    check("rst_res",       {res_valid[0], res_id[0], res_match[0], res_ovf[0]}, 0);
    check("rst_busy",      busy[0], 0);
    clr = 1'b0;
    @(negedge clk);

    act = 0;
    run_one(0, "1+(1+2)*(1*3) ", 1'b0, 1'b1, 1'b0, 14, 1'b1);
    run_one(1, "1+*2 ",          1'b0, 1'b0, 1'b0, 5,  1'b1);

    pulse_clr();
    run_pair("1 ",   "1+2 ", 1'b1, 1'b1);
    run_pair("(1) ", "1) ",  1'b1, 1'b0);
    check("one_ready_at_a_time", both_rdy, 0);

    run_one(1, "2 ",   1'b0, 1'b1, 1'b0, 2, 1'b1);
    run_one(1, "3*4 ", 1'b0, 1'b1, 1'b0, 4, 1'b1);
    run_one(1, "(5 ",  1'b0, 1'b0, 1'b0, 3, 1'b1);

    run_one(0, " ", 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Clear in the middle of the burst: outputs drop at once and no result appears.
    clear_obs();
    drive(0, "1+2*3 ", 1'b0);
    t = 0;
    while (rec_clr[0] && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("clr_reached_feed", rec_clr[0], 0);
    @(negedge clk);
    clr = 1'b1;
    #1;
    check("clr_rec_clr",   rec_clr[0], 1);
    check("clr_req_ready", rr[0], 0);
    check("clr_busy",      busy[0], 0);
    check("clr_res_valid", res_valid[0], 0);
    @(negedge clk);
    clr = 1'b0;
    repeat (5) @(negedge clk);
    check("clr_no_result", res_q.size(), 0);
    run_one(0, "1 ", 1'b0, 1'b1, 1'b0, 2, 1'b1);

    run_one(0, "(1+2)*3 ", 1'b1, 1'b1, 1'b0, 8, 1'b0);
    run_one(1, "((2)) ",   1'b1, 1'b1, 1'b0, 6, 1'b0);

    act = 1;
    @(negedge clk);
    run_one(0, "1+2+3 ", 1'b0, 1'b0, 1'b1, 0, 1'b0);
    run_one(0, "1+2+ ",  1'b0, 1'b0, 1'b0, 5, 1'b1);
    run_one(1, "1*2 ",   1'b0, 1'b1, 1'b0, 4, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
